// File: rtl/validator_pipe.sv
// validator_pipe: handshake-fed transaction filter, iterative hasher and output FIFO.
//
// A transaction is taken on i_valid & o_ready. It passes if amount is non-zero, sender and
// receiver differ, and its leading-zero count meets i_difficulty. A passing transaction is
// hashed for ROUNDS cycles and the hash is pushed into a FIFO_DEPTH-entry output queue.
// A failing transaction only bumps the reject counter.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   i_valid/o_ready upstream handshake (o_ready high only in idle)
//   i_transaction   {sender, receiver, amount, nonce}, DATA_W/4 bits each, MSB first
//   i_difficulty    required leading zeros, sampled at transfer
//   o_valid/i_ready downstream handshake on the FIFO head
//   o_hash          FIFO head (zero when empty)
//   o_accept_cnt    saturating count of passing transactions
//   o_reject_cnt    saturating count of failing transactions
//   o_busy          hashing or waiting to write
module validator_pipe #(
    parameter int unsigned       DATA_W     = 128,
    parameter int unsigned       ROUNDS     = 8,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] SEED       = '0,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_transaction,
    input  logic [7:0]        i_difficulty,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_hash,
    output logic [CNT_W-1:0]  o_accept_cnt,
    output logic [CNT_W-1:0]  o_reject_cnt,
    output logic              o_busy
);

    localparam int unsigned FW     = DATA_W / 4;
    localparam int unsigned RND_W  = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned LZ_W   = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StHash, StWrite} state_e;

    state_e              state_q;
    logic [DATA_W-1:0]   h_q;
    logic [RND_W-1:0]    rnd_q;
    logic [CNT_W-1:0]    acc_q;
    logic [CNT_W-1:0]    rej_q;

    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wptr_q;
    logic [PTR_W-1:0]    rptr_q;
    logic [FCNT_W-1:0]   count_q;
    logic [FCNT_W-1:0]   count_d;

    logic                take;
    logic                pass;
    logic [LZ_W-1:0]     lz;
    logic [DATA_W-1:0]   h_next;
    logic                push;
    logic                pop;

    function automatic logic [LZ_W-1:0] lzc(input logic [DATA_W-1:0] v);
        logic [LZ_W-1:0] n;
        logic            found;
        n     = '0;
        found = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + LZ_W'(1);
            end
        end
        return n;
    endfunction

    always_comb begin
        lz   = lzc(i_transaction);
        pass = (i_transaction[2*FW-1 -: FW] != '0)
            && (i_transaction[4*FW-1 -: FW] != i_transaction[3*FW-1 -: FW])
            && (32'(lz) >= 32'(i_difficulty));
    end

    assign take   = i_valid && (state_q == StIdle);
    assign h_next = {h_q[DATA_W-6:0], h_q[DATA_W-1 -: 5]} ^ (h_q >> 3) ^ DATA_W'(rnd_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            h_q     <= '0;
            rnd_q   <= '0;
            acc_q   <= '0;
            rej_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (take) begin
                        if (pass) begin
                            h_q     <= i_transaction ^ SEED;
                            rnd_q   <= '0;
                            state_q <= StHash;
                            if (acc_q != '1) acc_q <= acc_q + CNT_W'(1);
                        end else if (rej_q != '1) begin
                            rej_q <= rej_q + CNT_W'(1);
                        end
                    end
                end
                StHash: begin
                    h_q   <= h_next;
                    rnd_q <= rnd_q + RND_W'(1);
                    if (rnd_q == RND_W'(ROUNDS - 1)) state_q <= StWrite;
                end
                StWrite: begin
                    if (push) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Push looks at the pre-pop count, so a full FIFO never passes a hash straight through.
    assign push = (state_q == StWrite) && (count_q < FCNT_W'(FIFO_DEPTH));
    assign pop  = (count_q != '0) && i_ready;

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + FCNT_W'(1);
        else if (!push && pop) count_d = count_q - FCNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
        end
    end

    // Storage needs no reset: o_hash is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= h_q;
    end

    assign o_ready      = (state_q == StIdle);
    assign o_busy       = (state_q != StIdle);
    assign o_valid      = (count_q != '0);
    assign o_hash       = o_valid ? mem_q[rptr_q] : '0;
    assign o_accept_cnt = acc_q;
    assign o_reject_cnt = rej_q;

endmodule

// File: tb/tb_validator_pipe.sv
// Self-checking bench for validator_pipe (DATA_W=32, ROUNDS=4, FIFO_DEPTH=4, CNT_W=4).
module tb_validator_pipe;

    localparam int DW = 32;
    localparam int RN = 4;
    localparam int FD = 4;
    localparam int CW = 4;
    localparam logic [DW-1:0] SEED_TB = '0;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_transaction;
    logic [7:0]    i_difficulty;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_hash;
    logic [CW-1:0] o_accept_cnt;
    logic [CW-1:0] o_reject_cnt;
    logic          o_busy;

    int checks = 0;
    int errors = 0;
    int acc_m  = 0;
    int rej_m  = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic [DW-1:0] txn;
        logic [7:0]    diff;
        logic          pass;
    } vec_t;
    vec_t vecs[10];

    validator_pipe #(
        .DATA_W    (DW),
        .ROUNDS    (RN),
        .FIFO_DEPTH(FD),
        .SEED      (SEED_TB),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_transaction(i_transaction),
        .i_difficulty (i_difficulty),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_hash       (o_hash),
        .o_accept_cnt (o_accept_cnt),
        .o_reject_cnt (o_reject_cnt),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] model_hash(input logic [DW-1:0] t);
        logic [DW-1:0] h;
        h = t ^ SEED_TB;
        for (int r = 0; r < RN; r++) begin
            h = {h[DW-6:0], h[DW-1:DW-5]} ^ (h >> 3) ^ DW'(r);
        end
        return h;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnts(input string name);
        check({name, "_acc"}, 64'(o_accept_cnt), 64'(acc_m));
        check({name, "_rej"}, 64'(o_reject_cnt), 64'(rej_m));
    endtask

    // Offer one transaction; expectation for pass/fail comes from the caller's table.
    task automatic send(input logic [DW-1:0] t, input logic [7:0] d, input logic exp_pass);
        int n;
        n = 0;
        while (!o_ready && n < 100) begin
            step();
            n++;
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got o_ready=0 expected 1");
        end
        i_valid       = 1'b1;
        i_transaction = t;
        i_difficulty  = d;
        step();
        i_valid = 1'b0;
        if (exp_pass) begin
            exp_q.push_back(model_hash(t));
            if (acc_m < 15) acc_m++;
        end else begin
            if (rej_m < 15) rej_m++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        i_ready = 1'b1;
        while ((exp_q.size() != 0 || o_valid || o_busy) && n < 300) begin
            step();
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: a pop happens at the next rising edge whenever valid & ready here.
    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got hash %0h expected none", o_hash);
            end else begin
                check("hash_out", 64'(o_hash), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h01020500, 8'd0,  1'b1};
        vecs[1] = '{32'h03030501, 8'd0,  1'b0};
        vecs[2] = '{32'h01020000, 8'd0,  1'b0};
        vecs[3] = '{32'h00FF0133, 8'd8,  1'b1};
        vecs[4] = '{32'h00FF0133, 8'd9,  1'b0};
        vecs[5] = '{32'h00011122, 8'd15, 1'b1};
        vecs[6] = '{32'h00011122, 8'd16, 1'b0};
        vecs[7] = '{32'h80112233, 8'd1,  1'b0};
        vecs[8] = '{32'h80112233, 8'd0,  1'b1};
        vecs[9] = '{32'h00000000, 8'd32, 1'b0};

        rst           = 1'b1;
        i_valid       = 1'b0;
        i_ready       = 1'b0;
        i_transaction = '0;
        i_difficulty  = '0;
        repeat (2) step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_hash", 64'(o_hash), 64'd0);
        check_cnts("rst");

        // Reset in the middle of hashing discards everything
        send(32'h0A0B0C0D, 8'd0, 1'b1);
        step();
        step();
        check("midhash_busy", 64'(o_busy), 64'd1);
        #2 rst = 1'b1;
        exp_q.delete();
        acc_m = 0;
        rej_m = 0;
        #1;
        check("midrst_ready", 64'(o_ready), 64'd1);
        check("midrst_busy", 64'(o_busy), 64'd0);
        check_cnts("midrst");
        step();
        rst = 1'b0;
        repeat (12) step();
        check("midrst_nopush", 64'(o_valid), 64'd0);

        // Latency: push at edge T+ROUNDS+1
        i_ready = 1'b0;
        send(32'h01020500, 8'd0, 1'b1);
        check("lat_busy", 64'(o_busy), 64'd1);
        check("lat_ready", 64'(o_ready), 64'd0);
        for (int c = 1; c <= RN; c++) begin
            step();
            check("lat_early_valid", 64'(o_valid), 64'd0);
        end
        step();
        check("lat_valid", 64'(o_valid), 64'd1);
        check("lat_hash", 64'(o_hash), 64'(model_hash(32'h01020500)));
        check_cnts("lat");
        drain();

        // Table of pass/fail patterns
        i_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].txn, vecs[i].diff, vecs[i].pass);
            check_cnts("vec");
        end
        drain();

        // Difficulty boundary: lzc 7 rejected, lzc 8 accepted
        send(32'h01020304, 8'd8, 1'b0);
        check_cnts("diff_lz7");
        send(32'h00800500, 8'd8, 1'b1);
        check_cnts("diff_lz8");
        drain();

        // Back-to-back rejects, ready stays high; counter saturates at 15
        for (int k = 0; k < 17; k++) begin
            send(32'h05050100 + DW'(k), 8'd0, 1'b0);
            check("rej_ready", 64'(o_ready), 64'd1);
        end
        check("rej_sat", 64'(o_reject_cnt), 64'd15);
        check("rej_novalid", 64'(o_valid), 64'd0);

        // Backpressure: four queued, fifth held in write
        i_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(32'h10200100 + DW'(k), 8'd0, 1'b1);
        end
        repeat (RN + 2) step();
        check("bp_busy", 64'(o_busy), 64'd1);
        check("bp_ready", 64'(o_ready), 64'd0);
        check("bp_valid", 64'(o_valid), 64'd1);
        check("bp_head_held", 64'(o_hash), 64'(exp_q[0]));
        i_ready = 1'b1;
        send(32'h10200105, 8'd0, 1'b1);
        drain();
        check_cnts("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
